// File: rtl/led_pattern_arbiter.sv
// Three-requester fixed-priority LED arbiter with a minimum-hold preemption rule.
// The owner's live pattern and mode are rendered onto a 4-bit LED bank, stepped by a prescaled tick.
module led_pattern_arbiter #(
    parameter int unsigned TICK_DIV = 112_500_000,
    parameter int unsigned MIN_HOLD = 4
) (
    input  logic        osc_clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [11:0] pat,
    input  logic [5:0]  mode,
    output logic [2:0]  gnt,
    output logic [3:0]  led,
    output logic        tick
);

    localparam int unsigned     CW       = $clog2(TICK_DIV);
    localparam logic [CW-1:0]   LAST     = CW'(TICK_DIV - 1);
    localparam logic [3:0]      HOLD_MAX = 4'(MIN_HOLD);

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [3:0]    hold;
    logic [1:0]    phase;

    logic [2:0]    top_gnt;
    logic          owner_kept;
    logic          higher_req;
    logic [3:0]    own_pat;
    logic [1:0]    own_mode;
    logic [3:0]    led_next;

    // tick rises in the cycle after the count sits on its last value
    always_ff @(posedge osc_clk) begin
        if (rst) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            tick  <= (count == LAST);
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    always_comb begin
        top_gnt = 3'b000;
        if (req[2])      top_gnt = 3'b100;
        else if (req[1]) top_gnt = 3'b010;
        else if (req[0]) top_gnt = 3'b001;
    end

    assign owner_kept = |(req & gnt);
    assign higher_req = (gnt[0] && (req[2] || req[1])) || (gnt[1] && req[2]);

    // A grant change always restarts hold and phase, even on a tick cycle
    always_ff @(posedge osc_clk) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= 3'b000;
            hold  <= 4'd0;
            phase <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state <= OWN;
                        gnt   <= top_gnt;
                        hold  <= 4'd0;
                        phase <= 2'd0;
                    end
                end
                OWN: begin
                    if (!owner_kept) begin
                        state <= (|req) ? OWN : IDLE;
                        gnt   <= top_gnt;
                        hold  <= 4'd0;
                        phase <= 2'd0;
                    end else if (higher_req && (hold >= HOLD_MAX)) begin
                        gnt   <= top_gnt;
                        hold  <= 4'd0;
                        phase <= 2'd0;
                    end else if (tick) begin
                        if (hold < HOLD_MAX) hold <= hold + 4'd1;
                        phase <= phase + 2'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 3'b000;
                    hold  <= 4'd0;
                    phase <= 2'd0;
                end
            endcase
        end
    end

    always_comb begin
        own_pat  = 4'b0000;
        own_mode = 2'b00;
        case (gnt)
            3'b001: begin own_pat = pat[3:0];  own_mode = mode[1:0]; end
            3'b010: begin own_pat = pat[7:4];  own_mode = mode[3:2]; end
            3'b100: begin own_pat = pat[11:8]; own_mode = mode[5:4]; end
            default: begin own_pat = 4'b0000; own_mode = 2'b00; end
        endcase
    end

    // Solid, blink, chase (rotate left by phase), alternate
    always_comb begin
        led_next = own_pat;
        case (own_mode)
            2'b00: led_next = own_pat;
            2'b01: led_next = phase[0] ? 4'b0000 : own_pat;
            2'b10: begin
                case (phase)
                    2'd0:    led_next = own_pat;
                    2'd1:    led_next = {own_pat[2:0], own_pat[3]};
                    2'd2:    led_next = {own_pat[1:0], own_pat[3:2]};
                    default: led_next = {own_pat[0], own_pat[3:1]};
                endcase
            end
            default: led_next = phase[0] ? ~own_pat : own_pat;
        endcase
    end

    always_ff @(posedge osc_clk) begin
        if (rst) led <= 4'b0000;
        else     led <= (gnt == 3'b000) ? 4'b0000 : led_next;
    end

endmodule

// File: tb/tb_led_pattern_arbiter.sv
// Bench for led_pattern_arbiter: two instances (TICK_DIV 4 and 2) share stimulus and are scored
// against an integer-level reference model through expected queues.
module tb_led_pattern_arbiter;

    localparam int MIN_HOLD = 2;

    logic        osc_clk;
    logic        rst;
    logic [2:0]  req;
    logic [11:0] pat;
    logic [5:0]  mode;
    logic [2:0]  gnt_a, gnt_b;
    logic [3:0]  led_a, led_b;
    logic        tick_a, tick_b;

    int checks = 0;
    int passes = 0;

    logic [7:0] exp_a_q[$];
    logic [7:0] exp_b_q[$];

    typedef struct {
        int cnt;
        int tk;
        int owner;
        int hold;
        int phase;
        int led;
    } mstate_t;

    mstate_t ma, mb;

    led_pattern_arbiter #(.TICK_DIV(4), .MIN_HOLD(MIN_HOLD)) dut_a (
        .osc_clk(osc_clk), .rst(rst), .req(req), .pat(pat), .mode(mode),
        .gnt(gnt_a), .led(led_a), .tick(tick_a)
    );

    led_pattern_arbiter #(.TICK_DIV(2), .MIN_HOLD(MIN_HOLD)) dut_b (
        .osc_clk(osc_clk), .rst(rst), .req(req), .pat(pat), .mode(mode),
        .gnt(gnt_b), .led(led_b), .tick(tick_b)
    );

    // clock / reset
    initial begin
        osc_clk = 1'b0;
        forever #5 osc_clk = ~osc_clk;
    end

    function automatic mstate_t reset_state();
        mstate_t s;
        s.cnt = 0; s.tk = 0; s.owner = -1; s.hold = 0; s.phase = 0; s.led = 0;
        return s;
    endfunction

    // Reference: what the outputs must be after one edge, from pre-edge state and inputs
    function automatic mstate_t step(mstate_t s, logic r, logic [2:0] rq, logic [11:0] p,
                                     logic [5:0] md, int div);
        mstate_t n;
        int top, pv, mv, ph;
        if (r) return reset_state();
        n = s;
        n.tk  = (s.cnt == div - 1) ? 1 : 0;
        n.cnt = (s.cnt + 1) % div;
        if (s.owner < 0) begin
            n.led = 0;
        end else begin
            pv = (p >> (4 * s.owner)) & 15;
            mv = (md >> (2 * s.owner)) & 3;
            ph = s.phase;
            case (mv)
                0: n.led = pv;
                1: n.led = (ph % 2 == 0) ? pv : 0;
                2: n.led = ((pv << ph) | (pv >> (4 - ph))) & 15;
                default: n.led = (ph % 2 == 0) ? pv : (~pv & 15);
            endcase
        end
        top = -1;
        for (int i = 0; i < 3; i++) if (rq[i]) top = i;
        if (s.owner < 0 || !rq[s.owner] || (top > s.owner && s.hold >= MIN_HOLD)) begin
            if (top != s.owner) begin
                n.owner = top; n.hold = 0; n.phase = 0;
            end
        end else if (s.tk != 0) begin
            n.hold  = (s.hold + 1 > MIN_HOLD) ? MIN_HOLD : s.hold + 1;
            n.phase = (s.phase + 1) % 4;
        end
        return n;
    endfunction

    function automatic logic [7:0] pack(mstate_t s);
        logic [2:0] g;
        g = (s.owner < 0) ? 3'b000 : 3'(1 << s.owner);
        return {g, 4'(s.led), 1'(s.tk)};
    endfunction

    // driver: inputs change on the falling edge, expectation queued for the next rising edge
    task automatic drive(input logic r, input logic [2:0] rq, input logic [11:0] p,
                         input logic [5:0] md);
        @(negedge osc_clk);
        rst = r; req = rq; pat = p; mode = md;
        ma = step(ma, r, rq, p, md, 4);
        mb = step(mb, r, rq, p, md, 2);
        exp_a_q.push_back(pack(ma));
        exp_b_q.push_back(pack(mb));
    endtask

    task automatic hold_inputs(input int n, input logic [2:0] rq, input logic [11:0] p,
                               input logic [5:0] md);
        for (int i = 0; i < n; i++) drive(1'b0, rq, p, md);
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        else
            passes++;
    endtask

    // scoreboard monitor
    always @(posedge osc_clk) begin
        logic [7:0] e;
        #1;
        if (exp_a_q.size() > 0) begin
            e = exp_a_q.pop_front();
            check("a_gnt",  {1'b0, gnt_a},  {1'b0, e[7:5]});
            check("a_led",  led_a,          e[4:1]);
            check("a_tick", {3'b000, tick_a}, {3'b000, e[0]});
        end
        if (exp_b_q.size() > 0) begin
            e = exp_b_q.pop_front();
            check("b_gnt",  {1'b0, gnt_b},  {1'b0, e[7:5]});
            check("b_led",  led_b,          e[4:1]);
            check("b_tick", {3'b000, tick_b}, {3'b000, e[0]});
        end
    end

    initial begin
        logic [2:0]  rq;
        logic [11:0] p;
        logic [5:0]  md;
        rst = 1'b1; req = 3'b000; pat = 12'h000; mode = 6'b000000;
        ma = reset_state();
        mb = reset_state();

        repeat (3) drive(1'b1, 3'b000, 12'h000, 6'b000000);

        // grant and solid mode
        hold_inputs(12, 3'b001, 12'h00A, 6'b000000);
        // chase on requester 1
        hold_inputs(2, 3'b000, 12'h010, 6'b001000);
        hold_inputs(24, 3'b010, 12'h010, 6'b001000);
        // preemption of a blinking owner
        hold_inputs(2, 3'b000, 12'h50C, 6'b000001);
        hold_inputs(5, 3'b001, 12'h50C, 6'b000001);
        hold_inputs(20, 3'b101, 12'h50C, 6'b000001);
        // owner 100 releases as req[1] rises, req[0] held
        hold_inputs(10, 3'b011, 12'h369, 6'b011011);
        // reset mid-ownership with all requests held
        hold_inputs(6, 3'b111, 12'h9C3, 6'b110110);
        drive(1'b1, 3'b111, 12'h9C3, 6'b110110);
        hold_inputs(8, 3'b111, 12'h9C3, 6'b110110);
        // alternate mode long enough for phase to wrap
        hold_inputs(2, 3'b000, 12'h600, 6'b110000);
        hold_inputs(30, 3'b100, 12'h600, 6'b110000);

        // random traffic
        rq = 3'b000; p = 12'h000; md = 6'b000000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) rq = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) p  = 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 19) == 0) md = 6'($urandom_range(0, 63));
            drive(($urandom_range(0, 299) == 0), rq, p, md);
        end

        repeat (3) @(posedge osc_clk);
        #2;
        checks++;
        if (exp_a_q.size() + exp_b_q.size() != 0)
            $display("FAIL drain: got %0d pending expected 0", exp_a_q.size() + exp_b_q.size());
        else
            passes++;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
